// File: rtl/k_and_s_pkg.sv
// Shared types and helpers for the K&S processor: instruction decode,
// control FSM states, ALU op codes and the branch-taken rule.
package k_and_s_pkg;

  // Decoded IR contents as produced by data_path. Values above I_HALT are
  // unassigned encodings and are treated like NOP by the control unit.
  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ALU    = 4'd5,
    S_BRANCH = 4'd6,
    S_NEXT   = 4'd7,
    S_HALT   = 4'd8
  } ctrl_state_type;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Branch decision from the registered flags; non-branch encodings never take.
  function automatic logic branch_taken(decoded_instruction_type di,
                                        logic zero, logic neg, logic uov);
    logic t;
    t = 1'b0;
    case (di)
      I_BRANCH: t = 1'b1;
      I_BZERO:  t = zero;
      I_BNZERO: t = ~zero;
      I_BNEG:   t = neg;
      I_BNNEG:  t = ~neg;
      I_BOV:    t = uov;
      I_BNOV:   t = ~uov;
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch, decode, execute, PC update; parks in
// S_HALT until reset. All outputs are decoded from the state register.
module control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
);

  ctrl_state_type state, state_nxt;

  // Signed overflow is reserved for future branch types.
  logic unused_sovf;
  assign unused_sovf = signed_overflow;

  // State register; async reset drops any in-flight strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Next-state: linear sequencing plus dispatch out of S_DECODE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (decoded_instruction)
          I_LOAD:  state_nxt = S_LOAD;
          I_STORE: state_nxt = S_STORE;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR: state_nxt = S_ALU;
          I_HALT:  state_nxt = S_HALT;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
            state_nxt = branch_taken(decoded_instruction, zero_op, neg_op,
                                     unsigned_overflow) ? S_BRANCH : S_NEXT;
          default: state_nxt = S_NEXT;
        endcase
      end
      S_LOAD, S_STORE, S_ALU: state_nxt = S_NEXT;
      S_BRANCH, S_NEXT:       state_nxt = S_FETCH;
      S_HALT:                 state_nxt = S_HALT;
      default:                state_nxt = S_INIT;
    endcase
  end

  // Moore outputs; S_ALU also looks at the IR, which is stable outside S_FETCH.
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = OP_ADD;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (state)
      S_FETCH: ir_enable = 1'b1;
      S_LOAD: begin
        addr_sel         = 1'b1;
        write_reg_enable = 1'b1;
      end
      S_STORE: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
      end
      S_ALU: begin
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        case (decoded_instruction)
          I_ADD: begin operation = OP_ADD; flags_reg_enable = 1'b1; end
          I_SUB: begin operation = OP_SUB; flags_reg_enable = 1'b1; end
          I_AND: begin operation = OP_AND; flags_reg_enable = 1'b1; end
          I_OR:  begin operation = OP_OR;  flags_reg_enable = 1'b1; end
          // MOVE passes A through as A|A and leaves the flags untouched.
          I_MOVE: operation = OP_OR;
          default: ;
        endcase
      end
      S_BRANCH: begin
        branch    = 1'b1;
        pc_enable = 1'b1;
      end
      S_NEXT:  pc_enable = 1'b1;
      S_HALT:  halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Random instruction stream checked cycle by cycle against an
// instruction-level model of the expected control words.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  decoded_instruction_type di = I_NOP;
  logic zero_op = 1'b0, neg_op = 1'b0, uov = 1'b0, sov = 1'b0;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic write_reg_enable, flags_reg_enable, ram_write_enable, halt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .decoded_instruction(di),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uov),
    .signed_overflow(sov), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .ram_write_enable(ram_write_enable),
    .halt(halt)
  );

  // Control word: {halt, ram_we, flags_en, wr_en, op[1:0], c_sel, addr_sel, ir_en, pc_en, branch}
  function automatic logic [10:0] cw(logic h, logic rw, logic fe, logic we,
                                     logic [1:0] op, logic cs, logic as_,
                                     logic ie, logic pe, logic br);
    return {h, rw, fe, we, op, cs, as_, ie, pe, br};
  endfunction

  function automatic logic [10:0] obs();
    return {halt, ram_write_enable, flags_reg_enable, write_reg_enable, operation,
            c_sel, addr_sel, ir_enable, pc_enable, branch};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle control words of one instruction, starting at its fetch.
  function automatic void model(input decoded_instruction_type d, input logic z,
                                input logic n, input logic v, ref logic [10:0] q[$]);
    logic tk;
    q.delete();
    q.push_back(cw(0,0,0,0,2'b00,0,0,1,0,0));   // fetch
    q.push_back('0);                            // decode
    tk = (d == I_BRANCH) || (d == I_BZERO && z) || (d == I_BNZERO && !z) ||
         (d == I_BNEG && n) || (d == I_BNNEG && !n) ||
         (d == I_BOV && v) || (d == I_BNOV && !v);
    case (d)
      I_LOAD:  q.push_back(cw(0,0,0,1,2'b00,0,1,0,0,0));
      I_STORE: q.push_back(cw(0,1,0,0,2'b00,0,1,0,0,0));
      I_ADD:   q.push_back(cw(0,0,1,1,2'b00,1,0,0,0,0));
      I_SUB:   q.push_back(cw(0,0,1,1,2'b01,1,0,0,0,0));
      I_AND:   q.push_back(cw(0,0,1,1,2'b10,1,0,0,0,0));
      I_OR:    q.push_back(cw(0,0,1,1,2'b11,1,0,0,0,0));
      I_MOVE:  q.push_back(cw(0,0,0,1,2'b11,1,0,0,0,0));
      I_HALT:  begin q.push_back(cw(1,0,0,0,2'b00,0,0,0,0,0)); return; end
      default: ;
    endcase
    if (tk) q.push_back(cw(0,0,0,0,2'b00,0,0,0,1,1));
    else    q.push_back(cw(0,0,0,0,2'b00,0,0,0,1,0));
  endfunction

  task automatic run_instr(input decoded_instruction_type d, input logic z,
                           input logic n, input logic v, input string tag);
    logic [10:0] q[$];
    di = d; zero_op = z; neg_op = n; uov = v; sov = $urandom_range(0, 1);
    model(d, z, n, v, q);
    foreach (q[i]) begin
      @(posedge clk); #1;
      check($sformatf("%s %s c%0d", tag, d.name(), i + 2), {21'd0, obs()}, {21'd0, q[i]});
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    #1 check("reset_async", {21'd0, obs()}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("init_cycle", {21'd0, obs()}, 32'd0);
  endtask

  initial begin
    decoded_instruction_type d;
    logic [10:0] hw;
    // Reset and directed NOP/ALU/memory/branch cases
    #2 check("reset_hold", {21'd0, obs()}, 32'd0);
    do_reset();
    run_instr(I_NOP, 0, 0, 0, "dir");
    run_instr(I_ADD, 0, 0, 0, "dir");
    run_instr(I_MOVE, 0, 0, 0, "dir");
    run_instr(I_STORE, 0, 0, 0, "dir");
    run_instr(I_LOAD, 0, 0, 0, "dir");
    for (int k = 0; k < 2; k++) begin
      run_instr(I_BZERO, k[0], 0, 0, "dir");
      run_instr(I_BNZERO, k[0], 0, 0, "dir");
      run_instr(I_BNEG, 0, k[0], 0, "dir");
      run_instr(I_BNNEG, 0, k[0], 0, "dir");
      run_instr(I_BOV, 0, 0, k[0], "dir");
      run_instr(I_BNOV, 0, 0, k[0], "dir");
    end
    run_instr(decoded_instruction_type'(5'd21), 1, 1, 1, "unlisted");

    // Random stream (HALT excluded; unlisted encodings sometimes)
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) d = decoded_instruction_type'(5'($urandom_range(16, 31)));
      else begin
        d = decoded_instruction_type'(5'($urandom_range(0, 14)));
      end
      run_instr(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), "rnd");
    end

    // Async reset in the middle of an ALU execute cycle
    di = I_SUB;
    @(posedge clk); #1 check("mid_fetch", {31'd0, ir_enable}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1 check("mid_alu_we", {31'd0, write_reg_enable}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_we", {31'd0, write_reg_enable}, 32'd0);
    check("mid_rst_all", {21'd0, obs()}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("restart_init", {21'd0, obs()}, 32'd0);
    run_instr(I_NOP, 0, 0, 0, "restart");

    // HALT is sticky until reset
    run_instr(I_HALT, 0, 0, 0, "halt");
    hw = cw(1,0,0,0,2'b00,0,0,0,0,0);
    for (int k = 0; k < 22; k++) begin
      di = decoded_instruction_type'(5'($urandom_range(0, 31)));
      zero_op = 1'($urandom_range(0, 1));
      @(posedge clk); #1 check($sformatf("halt_hold%0d", k), {21'd0, obs()}, {21'd0, hw});
    end
    #2 rst_n = 1'b0;
    #1 check("halt_rst", {31'd0, halt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("post_halt_init", {21'd0, obs()}, 32'd0);
    run_instr(I_OR, 0, 0, 0, "post_halt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control FSM of the K&S processor. It sits directly upstream of `data_path`: it consumes `decoded_instruction` and the registered ALU flags, and drives every datapath control strobe plus the RAM write enable. It sequences each instruction through fetch, decode, execute and PC update, and stops permanently on HALT until reset.

## Interface
Parameters: none.

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `decoded_instruction`  in  `decoded_instruction_type`  current IR contents, decoded by `data_path`
- `zero_op`  in  1  registered zero flag
- `neg_op`  in  1  registered negative flag
- `unsigned_overflow`  in  1  registered unsigned-overflow flag
- `signed_overflow`  in  1  registered signed-overflow flag; unused by branches, kept for ISA extension
- `branch`  out  1  PC load source: 1 = instruction address, 0 = PC+1
- `pc_enable`  out  1  PC update strobe
- `ir_enable`  out  1  IR load strobe
- `addr_sel`  out  1  RAM address source: 0 = PC, 1 = instruction address field
- `c_sel`  out  1  register write source: 1 = ALU, 0 = `data_in`
- `operation`  out  2  ALU op: 00 add, 01 sub, 10 and, 11 or
- `write_reg_enable`  out  1  register-file write strobe
- `flags_reg_enable`  out  1  flag-register update strobe
- `ram_write_enable`  out  1  RAM write strobe (STORE)
- `halt`  out  1  high while in S_HALT

## Operation
- States: S_INIT, S_FETCH, S_DECODE, S_LOAD, S_STORE, S_ALU, S_BRANCH, S_NEXT, S_HALT.
- Outputs are Moore outputs: a function of the state register, plus `decoded_instruction` in S_ALU only, which is stable because the IR only loads in S_FETCH.
- Every output not listed for a state is 0.
- **S_INIT**: all outputs 0. Next state is S_FETCH.
- **S_FETCH**: `addr_sel`=0, `ir_enable`=1. Next state is S_DECODE.
- **S_DECODE**: all outputs 0. Dispatch on `decoded_instruction`:
  - LOAD goes to S_LOAD; STORE goes to S_STORE.
  - MOVE, ADD, SUB, AND and OR go to S_ALU.
  - HALT goes to S_HALT.
  - BRANCH always goes to S_BRANCH.
  - BZERO/BNZERO go to S_BRANCH if `zero_op`=1/0; BNEG/BNNEG if `neg_op`=1/0; BOV/BNOV if `unsigned_overflow`=1/0. Otherwise they go to S_NEXT.
  - NOP and any unlisted encoding go to S_NEXT.
- **S_LOAD**: `addr_sel`=1, `c_sel`=0, `write_reg_enable`=1. Next state is S_NEXT.
- **S_STORE**: `addr_sel`=1, `ram_write_enable`=1. Next state is S_NEXT.
- **S_ALU**: `c_sel`=1, `write_reg_enable`=1. Next state is S_NEXT.
  - `operation`: ADD 00, SUB 01, AND 10, OR 11, MOVE 11 (A|A=A).
  - `flags_reg_enable`=1 for ADD, SUB, AND and OR; 0 for MOVE, so flags are preserved across MOVE.
- **S_BRANCH**: `branch`=1, `pc_enable`=1. Next state is S_FETCH.
- **S_NEXT**: `pc_enable`=1, `branch`=0. Next state is S_FETCH.
- **S_HALT**: `halt`=1, all other outputs 0. The FSM stays in S_HALT until `rst_n` is asserted.

## Timing
- Reset: while `rst_n`=0 the state is forced asynchronously to S_INIT, so every output is 0 immediately, including `halt`. This also applies mid-instruction: a pending register/RAM write is dropped and the PC is not advanced.
- First fetch occurs in the 2nd cycle after reset deassertion.
- Cycles per instruction (state sequence is FETCH, DECODE, then the states listed):
  - LOAD, STORE, ALU ops: 4 (execute state, then S_NEXT).
  - Any branch, taken or not: 3 (S_BRANCH or S_NEXT).
  - NOP: 3 (S_NEXT).
  - HALT: reaches S_HALT in the 3rd cycle.
- Branch condition is sampled in S_DECODE from the registered flags. Flags written in S_ALU of instruction N are visible to a conditional branch at N+1.
- RAM read is combinational: `data_in` is valid in the same cycle as `addr_sel`/address. RAM write commits on the rising edge that ends S_STORE.
- The state register is the only storage; no output is registered separately.

## Structure
- `k_and_s_pkg` gains `ctrl_state_type`, an enum of the nine states.
- `k_and_s_pkg` gains the ALU op constants `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`, shared with `data_path`.
- The branch-taken decision is a package function `branch_taken(decoded_instruction, zero, neg, uov)` returning 1 bit.
- No sub-module: a single state register plus next-state and output `always_comb` blocks.
- Top level instantiates `control_unit` and `data_path` side by side. All control signals are point-to-point wires.

## Test plan
- Reset, then NOP in IR → states INIT, FETCH, DECODE, NEXT; `pc_enable` high only in cycle 4; `ir_enable` high only in cycle 2.
- ADD sequence → cycle 3 shows `operation`=00, `c_sel`=1, `write_reg_enable`=1, `flags_reg_enable`=1. Same with MOVE → `operation`=11, `flags_reg_enable`=0.
- BZERO with `zero_op`=1 → S_BRANCH with `branch`=1, `pc_enable`=1. Same with `zero_op`=0 → S_NEXT with `branch`=0. Repeat for BNEG/BNNEG/BOV/BNOV.
- STORE → cycle 3 shows `addr_sel`=1, `ram_write_enable`=1, `write_reg_enable`=0. LOAD → cycle 3 shows `addr_sel`=1, `c_sel`=0, `write_reg_enable`=1.
- HALT → `halt`=1 from cycle 3 and held for 20+ cycles with all strobes 0. Asserting `rst_n`=0 clears `halt` asynchronously.
- Assert `rst_n`=0 in S_ALU → `write_reg_enable` drops to 0 without waiting for a clock edge. Restart fetches from S_INIT.
